// File: rtl/m72_irq_source_if.sv
// CPU-side register bus of the M72 interrupt request source.
interface m72_irq_source_if;
    logic       cs;
    logic       wr;
    logic       rd;
    logic       a0;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output cs, wr, rd, a0, din, input dout);
    modport slave  (input cs, wr, rd, a0, din, output dout);
endinterface

// File: rtl/m72_irq_source.sv
// VBLANK and programmable RASTER interrupt requests for the PIC, stretched to PULSE_LEN ce cycles.
// Optional feature: define M72_IRQ_READBACK_EN to make the raster register readable on dout.
module m72_irq_source #(
    parameter int unsigned PULSE_LEN   = 16,
    parameter int unsigned VBL_BIT     = 0,
    parameter int unsigned RAST_BIT    = 2,
    parameter int unsigned RASTER_BASE = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    m72_irq_source_if.slave   bus,
    input  logic [8:0]        vcount,
    input  logic              hblank,
    input  logic              vblank,
    output logic [7:0]        intp
);

    localparam int unsigned CNT_W  = $clog2(PULSE_LEN + 1);
    localparam int unsigned LINE_W = 9;

    logic [LINE_W-1:0] raster_line;
    logic              raster_en;
    logic              vbl_d;
    logic              hbl_d;
    logic [CNT_W-1:0]  vbl_cnt;
    logic [CNT_W-1:0]  rast_cnt;

    logic [LINE_W-1:0] rast_target;
    logic              vbl_rise;
    logic              hbl_rise;
    logic              rast_hit;
    logic              cpu_wr;
    logic [CNT_W-1:0]  vbl_cnt_nxt;
    logic [CNT_W-1:0]  rast_cnt_nxt;
    logic [7:0]        intp_nxt;

    // Edge detect, raster compare (on the pre-write line value) and pulse stretchers
    always_comb begin
        rast_target  = LINE_W'(raster_line - LINE_W'(RASTER_BASE));
        vbl_rise     = vblank & ~vbl_d;
        hbl_rise     = hblank & ~hbl_d;
        rast_hit     = hbl_rise & raster_en & (vcount == rast_target);
        cpu_wr       = bus.cs & bus.wr;

        vbl_cnt_nxt  = vbl_cnt;
        rast_cnt_nxt = rast_cnt;
        if (vbl_rise)
            vbl_cnt_nxt = CNT_W'(PULSE_LEN);
        else if (vbl_cnt != '0)
            vbl_cnt_nxt = vbl_cnt - CNT_W'(1);
        if (rast_hit)
            rast_cnt_nxt = CNT_W'(PULSE_LEN);
        else if (rast_cnt != '0)
            rast_cnt_nxt = rast_cnt - CNT_W'(1);

        intp_nxt           = '0;
        intp_nxt[VBL_BIT]  = (vbl_cnt_nxt != '0);
        intp_nxt[RAST_BIT] = (rast_cnt_nxt != '0);
    end

    // Blank history starts high so a blank already active at reset release is ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            raster_line <= '0;
            raster_en   <= 1'b0;
            vbl_d       <= 1'b1;
            hbl_d       <= 1'b1;
            vbl_cnt     <= '0;
            rast_cnt    <= '0;
            intp        <= '0;
        end else if (ce) begin
            vbl_d    <= vblank;
            hbl_d    <= hblank;
            vbl_cnt  <= vbl_cnt_nxt;
            rast_cnt <= rast_cnt_nxt;
            intp     <= intp_nxt;
            if (cpu_wr) begin
                if (!bus.a0) begin
                    raster_line[7:0] <= bus.din;
                end else begin
                    raster_line[8] <= bus.din[0];
                    raster_en      <= bus.din[7];
                end
            end
        end
    end

`ifdef M72_IRQ_READBACK_EN
    logic unused_din;
    assign unused_din = ^bus.din[6:1];

    // Register readback, one clk after the read strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.dout <= '0;
        end else if (ce && bus.cs && bus.rd) begin
            if (!bus.a0)
                bus.dout <= raster_line[7:0];
            else
                bus.dout <= {raster_en, 5'b0, intp[RAST_BIT], raster_line[8]};
        end
    end
`else
    logic unused_bus;
    assign unused_bus = ^{bus.rd, bus.din[6:1]};

    always_ff @(posedge clk) begin
        bus.dout <= '0;
    end
`endif

endmodule
